qcv_prefetch_buffer_n: RTL
==========================

Name: qcv_prefetch_buffer_n

Overview:
Parametrised next-generation instruction prefetch buffer between the IF stage and the instruction memory port. It supports configurable FIFO depth and a configurable number of in-flight memory requests. In-flight requests are tracked by counters, so no per-slot shift register is needed. A branch flushes the buffer and squashes any number of outstanding responses. An optional halt-on-error mode, an occupancy output and an error-halted status are new relative to the previous generation.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (1..DEPTH)
HALT_ON_ERR, 1, 1 = stop issuing requests after an accepted err response until the next branch_i
RESET_ADDR, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_i  in  1  fetch enable from IF
branch_i  in  1  flush; restart fetching at addr_i
addr_i  in  32  branch target; bits [1:0] ignored and forced to 0
ready_i  in  1  consumer accepts the output this cycle
valid_o  out  1  output entry valid
rdata_o  out  32  instruction word
addr_o  out  32  address of rdata_o
err_o  out  1  fetch error for the entry
instr_req_o  out  1  memory request
instr_gnt_i  in  1  memory grant
instr_addr_o  out  32  request address
instr_rdata_i  in  32  response data
instr_err_i  in  1  response error
instr_rvalid_i  in  1  response valid, returned in grant order
occupancy_o  out  $clog2(DEPTH)+1  current FIFO entry count
halted_o  out  1  error-halt active
busy_o  out  1  outstanding != 0 or instr_req_o

Behaviour:
- Reset (asynchronous, rst_i=1):
  - valid_o, instr_req_o, busy_o, halted_o, err_o = 0; occupancy_o = 0; rdata_o and addr_o = 0.
  - fetch_addr = RESET_ADDR, resp_addr = RESET_ADDR; all counters 0.
- Counters: outstanding (granted, not yet answered) and discard (responses to drop), both 0..MAX_OUTSTANDING. occupancy is 0..DEPTH.
- Request condition: instr_req_o = req_i & ~halted & ~branch_i & (outstanding < MAX_OUTSTANDING) & (occupancy + outstanding - discard < DEPTH).
  - The credit rule guarantees every live response has a FIFO slot; the FIFO never overflows.
- instr_addr_o = fetch_addr. On a grant (instr_req_o & instr_gnt_i), fetch_addr += 4, wrapping mod 2^32.
- instr_req_o is combinational. Once asserted, the address is held stable until granted, unless branch_i or reset occurs.
- Response handling:
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise it is pushed as {instr_rdata_i, resp_addr, instr_err_i} and resp_addr += 4.
  - outstanding decrements on every rvalid. A grant and an rvalid in the same cycle leave outstanding unchanged.
- Output:
  - The head entry drives rdata_o, addr_o and err_o; valid_o = (occupancy != 0).
  - Pop on valid_o & ready_i.
  - Latency is 1 cycle: a response in cycle N is visible in cycle N+1. There is no bypass.
  - Push and pop in the same cycle keep occupancy unchanged; this is legal when full.
  - Pointers wrap modulo DEPTH.
- Branch (branch_i=1), taking priority over push, pop and grant in that cycle:
  - FIFO emptied; fetch_addr = resp_addr = {addr_i[31:2],2'b00}; halted cleared.
  - discard = outstanding_next, i.e. all unanswered requests. Any rvalid arriving in the branch cycle is itself dropped.
  - instr_req_o is forced 0 in the branch cycle; requests restart the next cycle.
- Halt-on-error (HALT_ON_ERR=1):
  - Pushing an entry with err=1 sets halted; no further requests are issued.
  - Live responses that are already outstanding are still pushed.
  - halted is cleared only by branch_i or reset.
  - With HALT_ON_ERR=0, halted_o is tied to 0.
- req_i=0 only stops new requests. Outstanding responses are still accepted and the FIFO still drains.
- An rvalid with outstanding==0 is a protocol violation; the design must ignore it, and the bench asserts it never happens.

Decomposition:
- qcv_pkg holds the shared constants: QCV_XLEN=32, QCV_INSTR_BYTES=4, and the entry width function (XLEN*2+1).
- One sub-module, qcv_sync_fifo: DEPTH and WIDTH parameters; push, pop, flush; head data, count. It is reusable by the LSU.
- Credit and discard counters, address tracking and the halt flag live in the top level.

Test Plan:
- Reset release, req_i=1, gnt always 1, rvalid 1 cycle after grant, ready_i=1 → addresses 0x0, 0x4, 0x8… issued back to back; valid_o first high 2 cycles after the first grant; addr_o matches rdata_o order.
- DEPTH=4, ready_i=0, memory always grants → exactly 4 grants total; instr_req_o drops; occupancy_o=4; raising ready_i resumes fetching one word per pop.
- MAX_OUTSTANDING=2, responses delayed 5 cycles → never more than 2 grants without an rvalid; busy_o=1 throughout.
- Two requests outstanding, branch_i with addr_i=0x103 → next instr_addr_o=0x100; both old rvalids dropped; first valid_o has addr_o=0x100; occupancy_o=0 after the branch cycle.
- Response at 0x8 with instr_err_i=1, HALT_ON_ERR=1 → entry has err_o=1; halted_o=1; no further instr_req_o; branch_i to 0x40 clears halted_o and fetching resumes at 0x40.
- rst_i asserted mid-stream with 2 outstanding and the FIFO at 3 → all outputs 0 immediately (asynchronous); after release fetching restarts at RESET_ADDR with occupancy_o=0.

Source files
------------

// File: rtl/qcv_pkg.sv
// Shared constants and types for the qcv fetch path.
//   QCV_XLEN        : datapath / address width
//   QCV_INSTR_BYTES : bytes per fetched instruction word
//   qcv_entry_width : width of a packed {rdata, addr, err} buffer entry
package qcv_pkg;

    localparam int unsigned QCV_XLEN        = 32;
    localparam int unsigned QCV_INSTR_BYTES = 4;

    function automatic int unsigned qcv_entry_width(input int unsigned xlen);
        return xlen * 2 + 1;
    endfunction

    typedef struct packed {
        logic [QCV_XLEN-1:0] rdata;
        logic [QCV_XLEN-1:0] addr;
        logic                err;
    } qcv_entry_t;

endpackage

// File: rtl/qcv_sync_fifo.sv
// Synchronous FIFO with flush.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write wdata_i (accepted when full only together with pop_i)
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the FIFO; overrides push and pop
//   rdata_o      : head entry
//   count_o      : number of stored entries, 0..DEPTH
module qcv_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, push_en, pop_en;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_en  = pop_i & ~empty;
    // Full is fine when the head leaves in the same cycle.
    assign push_en = push_i & (~full | pop_en);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) wptr_q <= wptr_q + PtrW'(1);
            if (pop_en)  rptr_q <= rptr_q + PtrW'(1);
            if (push_en && !pop_en)      count_q <= count_q + CntW'(1);
            else if (!push_en && pop_en) count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset; entries are only observed while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (push_en && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/qcv_prefetch_buffer_n.sv
// Instruction prefetch buffer between IF and the instruction memory port.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_i                : fetch enable
//   branch_i, addr_i     : flush and restart fetching at addr_i (word aligned)
//   ready_i              : consumer takes the head entry
//   valid_o, rdata_o,
//   addr_o, err_o        : head entry (zero when empty)
//   instr_*              : memory request/grant/in-order response port
//   occupancy_o          : FIFO entry count
//   halted_o             : requests stopped after an error response
//   busy_o               : requests in flight or being issued
module qcv_prefetch_buffer_n
    import qcv_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned HALT_ON_ERR     = 1,
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   branch_i,
    input  logic [31:0]            addr_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [31:0]            rdata_o,
    output logic [31:0]            addr_o,
    output logic                   err_o,
    output logic                   instr_req_o,
    input  logic                   instr_gnt_i,
    output logic [31:0]            instr_addr_o,
    input  logic [31:0]            instr_rdata_i,
    input  logic                   instr_err_i,
    input  logic                   instr_rvalid_i,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   halted_o,
    output logic                   busy_o
);

    localparam int unsigned OccW   = $clog2(DEPTH) + 1;
    localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned EntryW = qcv_entry_width(QCV_XLEN);
    localparam logic [31:0] Step   = 32'(QCV_INSTR_BYTES);

    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     resp_addr_q, resp_addr_d;
    logic            halted_q, halted_d;

    logic [OccW-1:0]   occupancy;
    logic [EntryW-1:0] head_raw;
    qcv_entry_t        head, push_entry;
    logic [31:0]       in_flight, target;
    logic              grant, rvalid_live, push, pop;

    assign target = {addr_i[31:2], 2'b00};

    // Slots already promised: stored entries plus responses that will be kept.
    // discard_q never exceeds outstanding_q, so this cannot underflow.
    assign in_flight = 32'(occupancy) + 32'(outstanding_q) - 32'(discard_q);

    assign instr_req_o = ~rst_i & req_i & ~halted_q & ~branch_i
                       & (32'(outstanding_q) < MAX_OUTSTANDING)
                       & (in_flight < DEPTH);
    assign instr_addr_o = fetch_addr_q;
    assign grant        = instr_req_o & instr_gnt_i;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rvalid_live = instr_rvalid_i & (outstanding_q != '0);
    assign push        = rvalid_live & (discard_q == '0) & ~branch_i;
    assign pop         = valid_o & ready_i & ~branch_i;

    assign push_entry = '{rdata: instr_rdata_i, addr: resp_addr_q, err: instr_err_i};

    always_comb begin
        outstanding_d = outstanding_q;
        if (grant && !rvalid_live)      outstanding_d = outstanding_q + CntW'(1);
        else if (!grant && rvalid_live) outstanding_d = outstanding_q - CntW'(1);

        discard_d = discard_q;
        if (branch_i)                             discard_d = outstanding_d;
        else if (rvalid_live && discard_q != '0)  discard_d = discard_q - CntW'(1);

        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        if (branch_i) begin
            fetch_addr_d = target;
            resp_addr_d  = target;
        end else begin
            if (grant) fetch_addr_d = fetch_addr_q + Step;
            if (push)  resp_addr_d  = resp_addr_q + Step;
        end

        halted_d = halted_q;
        if (HALT_ON_ERR == 0)          halted_d = 1'b0;
        else if (branch_i)             halted_d = 1'b0;
        else if (push && instr_err_i)  halted_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            fetch_addr_q  <= RESET_ADDR;
            resp_addr_q   <= RESET_ADDR;
            halted_q      <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fetch_addr_q  <= fetch_addr_d;
            resp_addr_q   <= resp_addr_d;
            halted_q      <= halted_d;
        end
    end

    qcv_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_i),
        .wdata_i (push_entry),
        .rdata_o (head_raw),
        .count_o (occupancy)
    );

    assign head = head_raw;

    // Outputs read zero while empty so stale storage never leaks out.
    assign valid_o     = (occupancy != '0);
    assign rdata_o     = valid_o ? head.rdata : '0;
    assign addr_o      = valid_o ? head.addr : '0;
    assign err_o       = valid_o & head.err;
    assign occupancy_o = occupancy;
    assign halted_o    = halted_q;
    assign busy_o      = (outstanding_q != '0) | instr_req_o;

endmodule
